// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between the text-mode video fetcher and the CPU.
// Video has absolute priority; CPU writes are posted through a FIFO, CPU reads wait for it to drain.
module vram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock_25,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic [7:0]        vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, RDATA, ACK} state_t;

    state_t            state, state_next;
    logic              ack_next;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] rd_address;
    logic              fifo_empty, fifo_full;
    logic              push, pop, issue_read;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));

    // Port slot ownership: video first, then queued writes, then the pending read.
    assign pop        = !vid_req && !fifo_empty;
    assign issue_read = !vid_req && fifo_empty && (state == READ);
    assign push       = (state == IDLE) && cpu_req && cpu_we && !fifo_full;

    assign vid_data = mem_rdata;
    assign busy     = !fifo_empty || (state == READ) || (state == RDATA);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        mem_address = vid_address;
        mem_wdata   = fifo_data[rd_ptr];
        mem_we      = 1'b0;
        if (pop) begin
            mem_address = fifo_addr[rd_ptr];
            mem_we      = 1'b1;
        end else if (issue_read) begin
            mem_address = rd_address;
        end
    end

    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (!cpu_we) begin
                        state_next = READ;
                    end else if (!fifo_full) begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end
                end
            end
            READ:    if (issue_read) state_next = RDATA;
            RDATA: begin
                state_next = ACK;
                ack_next   = 1'b1;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            rd_address <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state   <= state_next;
            cpu_ack <= ack_next;
            if (state == IDLE && cpu_req && !cpu_we)
                rd_address <= cpu_address;
            if (state == RDATA)
                cpu_rdata <= mem_rdata;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clock_25) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_address;
            fifo_data[wr_ptr] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural VRAM with 1-cycle read latency,
// bus monitor on the falling edge, hand-computed expectations per scenario.
module tb_vram_arbiter;

    logic        clock_25;
    logic        reset_n;
    logic        vid_req;
    logic [12:0] vid_address;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        busy;

    vram_arbiter #(.ADDR_W(13), .FIFO_DEPTH(4)) dut (
        .clock_25    (clock_25),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_data    (vid_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    int cyc = 0;
    always @(posedge clock_25) cyc++;

    // VRAM model: unwritten locations read as addr[7:0]^0x6E (0x0010 -> 0x7E).
    logic [7:0] vram [int];
    always @(posedge clock_25) begin
        mem_rdata <= vram.exists(int'(mem_address)) ? vram[int'(mem_address)]
                                                    : (mem_address[7:0] ^ 8'h6E);
        if (mem_we) vram[int'(mem_address)] = mem_wdata;
    end

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_ev_t;

    wr_ev_t wlog[$];
    int     ack_cnt     = 0;
    int     wr_acks     = 0;
    int     mem_wr      = 0;
    int     rst_we_viol = 0;
    int     rd_cyc_1ffe = -1;
    bit     track_en    = 1'b0;
    int     track_base  = 0;
    int     omax        = 0;

    always @(negedge clock_25) begin
        if (cpu_ack) ack_cnt++;
        if (cpu_ack && cpu_we) wr_acks++;
        if (!reset_n && mem_we) rst_we_viol++;
        if (mem_we) begin
            mem_wr++;
            wlog.push_back('{addr: mem_address, data: mem_wdata, cyc: cyc});
        end
        if (!mem_we && !vid_req && mem_address == 13'h1FFE) rd_cyc_1ffe = cyc;
        if (track_en && (wr_acks - mem_wr - track_base) > omax)
            omax = wr_acks - mem_wr - track_base;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_25);
        #1;
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d, output int lat);
        bit acked = 1'b0;
        lat = -1;
        cpu_address = a;
        cpu_wdata   = d;
        cpu_we      = 1'b1;
        cpu_req     = 1'b1;
        for (int n = 1; n <= 40 && !acked; n++) begin
            @(posedge clock_25);
            @(negedge clock_25);
            if (cpu_ack) begin
                acked = 1'b1;
                lat   = n;
            end
        end
        check("write_ack_seen", 32'(acked), 32'd1);
        @(posedge clock_25);
        #1 cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [12:0] a, output logic [7:0] d, output int lat);
        bit acked = 1'b0;
        lat = -1;
        d   = 8'h00;
        cpu_address = a;
        cpu_we      = 1'b0;
        cpu_req     = 1'b1;
        for (int n = 1; n <= 60 && !acked; n++) begin
            @(posedge clock_25);
            @(negedge clock_25);
            if (cpu_ack) begin
                acked = 1'b1;
                lat   = n;
                d     = cpu_rdata;
            end
        end
        check("read_ack_seen", 32'(acked), 32'd1);
        @(posedge clock_25);
        #1 cpu_req = 1'b0;
    endtask

    task automatic vid_pattern(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            vid_req = ((i % 8) < 4);
            @(posedge clock_25);
            #1;
        end
        vid_req = 1'b0;
    endtask

    initial begin
        int          lat;
        int          base;
        int          acks0;
        int          wr_idx;
        logic [7:0]  rd;
        bit          ok;

        reset_n     = 1'b0;
        vid_req     = 1'b0;
        vid_address = 13'h0020;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        tick(3);
        reset_n = 1'b1;
        @(negedge clock_25);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'h00);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        // 1: reset with three posted writes still queued behind video.
        tick(1);
        vid_req = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(13'h0200 + 13'(i), 8'h10 + 8'(i), lat);
        @(negedge clock_25);
        check("t1_busy_before", 32'(busy), 32'd1);
        tick(1);
        acks0   = ack_cnt;
        base    = wlog.size();
        reset_n = 1'b0;
        vid_req = 1'b0;
        @(negedge clock_25);
        check("t1_busy_in_reset", 32'(busy), 32'd0);
        check("t1_we_in_reset", 32'(mem_we), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        @(negedge clock_25);
        check("t1_no_ack", 32'(ack_cnt - acks0), 32'd0);
        check("t1_no_writes", 32'(wlog.size() - base), 32'd0);
        check("t1_we_viol", 32'(rst_we_viol), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: video priority holds a posted write until vid_req drops.
        tick(1);
        vid_req = 1'b1;
        base    = wlog.size();
        cpu_write(13'h1000, 8'h41, lat);
        check("t2_write_lat", 32'(lat), 32'd1);
        tick(4);
        check("t2_no_write_under_vid", 32'(wlog.size() - base), 32'd0);
        vid_req = 1'b0;
        tick(3);
        check("t2_one_write", 32'(wlog.size() - base), 32'd1);
        if (wlog.size() > base) begin
            check("t2_addr", 32'(wlog[base].addr), 32'h1000);
            check("t2_data", 32'(wlog[base].data), 32'h41);
        end

        // 3: FIFO full; the 5th write waits until the first pop.
        vid_req = 1'b1;
        base    = wlog.size();
        for (int i = 0; i < 4; i++) begin
            cpu_write(13'h0100 + 13'(i), 8'hA0 + 8'(i), lat);
            check($sformatf("t3_lat%0d", i), 32'(lat), 32'd1);
        end
        acks0       = ack_cnt;
        cpu_address = 13'h0104;
        cpu_wdata   = 8'hA4;
        cpu_we      = 1'b1;
        cpu_req     = 1'b1;
        tick(4);
        @(negedge clock_25);
        check("t3_5th_no_ack", 32'(ack_cnt - acks0), 32'd0);
        check("t3_busy_full", 32'(busy), 32'd1);
        tick(1);
        vid_req = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            @(posedge clock_25);
            @(negedge clock_25);
            if (cpu_ack) lat = n;
        end
        check("t3_5th_ack_after_pop", 32'(lat), 32'd2);
        @(posedge clock_25);
        #1 cpu_req = 1'b0;
        tick(8);
        check("t3_write_count", 32'(wlog.size() - base), 32'd5);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (wlog.size() > base + i)
                ok &= (wlog[base+i].addr == 13'h0100 + 13'(i)) && (wlog[base+i].data == 8'hA0 + 8'(i));
        end
        check("t3_drain_order", 32'(ok), 32'd1);
        @(negedge clock_25);
        check("t3_busy_drained", 32'(busy), 32'd0);
        tick(1);

        // 4: read-after-write with a 4-on/4-off video pattern.
        base = wlog.size();
        fork
            vid_pattern(48);
            begin
                cpu_write(13'h1FFE, 8'h5A, lat);
                cpu_read(13'h1FFE, rd, lat);
            end
        join
        check("t4_rdata", 32'(rd), 32'h5A);
        wr_idx = -1;
        for (int i = base; i < wlog.size(); i++)
            if (wlog[i].addr == 13'h1FFE && wr_idx < 0) wr_idx = wlog[i].cyc;
        check("t4_write_before_read", 32'(wr_idx >= 0 && rd_cyc_1ffe > wr_idx), 32'd1);

        // 5: idle read latency is exactly 3; each video cycle adds one.
        tick(2);
        cpu_read(13'h0010, rd, lat);
        check("t5_lat", 32'(lat), 32'd3);
        check("t5_rdata", 32'(rd), 32'h7E);
        tick(2);
        @(negedge clock_25);
        check("t5_vid_data", 32'(vid_data), 32'h4E);
        tick(1);
        fork
            begin
                vid_req = 1'b1;
                repeat (3) @(posedge clock_25);
                #1 vid_req = 1'b0;
            end
            cpu_read(13'h0030, rd, lat);
        join
        check("t5_lat_vid2", 32'(lat), 32'd5);
        check("t5_rdata_vid2", 32'(rd), 32'h5E);

        // 6: ten writes wrap the pointers twice, then read back.
        tick(2);
        base       = wlog.size();
        track_base = wr_acks - mem_wr;
        track_en   = 1'b1;
        fork
            vid_pattern(64);
            for (int i = 0; i < 10; i++) cpu_write(13'h1000 + 13'(i), 8'hC0 + 8'(3 * i), lat);
        join
        tick(8);
        track_en = 1'b0;
        check("t6_max_outstanding", 32'(omax <= 4), 32'd1);
        check("t6_write_count", 32'(wlog.size() - base), 32'd10);
        check("t6_rdata_held", 32'(cpu_rdata), 32'h5E);
        for (int i = 0; i < 10; i++) begin
            cpu_read(13'h1000 + 13'(i), rd, lat);
            check($sformatf("t6_read%0d", i), 32'(rd), 32'(8'hC0 + 8'(3 * i)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
